// File: rtl/simon_round_ctrl.sv
// simon_round_ctrl: sequences SIMON key-schedule generation followed by an
// encrypt or decrypt pass over N_ROUNDS rounds, with round-key caching,
// abort, and a one-cycle done pulse.
module simon_round_ctrl #(
    parameter int unsigned  N_ROUNDS  = 32,
    parameter bit           KEY_CACHE = 1'b1,
    localparam int unsigned RW        = $clog2(N_ROUNDS)
) (
    input  logic          clk,
    input  logic          res_n,
    input  logic          start,
    input  logic          ctrl,
    input  logic          key_new,
    input  logic          abort,
    output logic [4:0]    state,
    output logic [RW-1:0] rnd_idx,
    output logic          key_gen_en,
    output logic          round_en,
    output logic          busy,
    output logic          done,
    output logic          key_valid
);

    typedef enum logic [4:0] {
        S_IDLE    = 5'b00001,
        S_KEY_GEN = 5'b00010,
        S_ENC     = 5'b00100,
        S_DEC     = 5'b01000,
        S_DONE    = 5'b10000
    } state_t;

    localparam logic [RW-1:0] LAST_IDX = RW'(N_ROUNDS - 1);
    localparam logic [RW-1:0] ZERO_IDX = '0;
    localparam logic [RW-1:0] ONE_IDX  = RW'(1);

    state_t        r_state;
    logic [RW-1:0] r_rnd_idx;
    logic          r_key_valid;
    logic          r_mode;
    logic          w_need_gen;

    // A fresh schedule is required for a new key, an incomplete schedule,
    // or when caching is disabled.
    assign w_need_gen = key_new | ~r_key_valid | ~KEY_CACHE;

    // Sequencer: abort beats everything; illegal encodings fall back to IDLE.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_state     <= S_IDLE;
            r_rnd_idx   <= ZERO_IDX;
            r_key_valid <= 1'b0;
            r_mode      <= 1'b0;
        end else if (abort) begin
            r_state   <= S_IDLE;
            r_rnd_idx <= ZERO_IDX;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mode <= ctrl;
                        if (w_need_gen) begin
                            r_state     <= S_KEY_GEN;
                            r_rnd_idx   <= ZERO_IDX;
                            r_key_valid <= 1'b0;
                        end else if (ctrl) begin
                            r_state   <= S_DEC;
                            r_rnd_idx <= LAST_IDX;
                        end else begin
                            r_state   <= S_ENC;
                            r_rnd_idx <= ZERO_IDX;
                        end
                    end
                end
                S_KEY_GEN: begin
                    if (r_rnd_idx == LAST_IDX) begin
                        r_key_valid <= 1'b1;
                        if (r_mode) begin
                            r_state   <= S_DEC;
                            r_rnd_idx <= LAST_IDX;
                        end else begin
                            r_state   <= S_ENC;
                            r_rnd_idx <= ZERO_IDX;
                        end
                    end else begin
                        r_rnd_idx <= r_rnd_idx + ONE_IDX;
                    end
                end
                S_ENC: begin
                    if (r_rnd_idx == LAST_IDX) begin
                        r_state <= S_DONE;
                    end else begin
                        r_rnd_idx <= r_rnd_idx + ONE_IDX;
                    end
                end
                S_DEC: begin
                    if (r_rnd_idx == ZERO_IDX) begin
                        r_state <= S_DONE;
                    end else begin
                        r_rnd_idx <= r_rnd_idx - ONE_IDX;
                    end
                end
                S_DONE: begin
                    r_state   <= S_IDLE;
                    r_rnd_idx <= ZERO_IDX;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_rnd_idx <= ZERO_IDX;
                end
            endcase
        end
    end

    // Strobes are pure decodes of the one-hot state register.
    assign state      = r_state;
    assign rnd_idx    = r_rnd_idx;
    assign key_valid  = r_key_valid;
    assign key_gen_en = (r_state == S_KEY_GEN);
    assign round_en   = (r_state == S_ENC) || (r_state == S_DEC);
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);

endmodule

// File: tb/tb_simon_round_ctrl.sv
// Scoreboard bench for simon_round_ctrl: two instances (32 rounds with key
// caching, 72 rounds without), random operations, aborts and async resets.
`timescale 1ns/1ps
module tb_simon_round_ctrl;

    localparam int unsigned NA  = 32;
    localparam int unsigned NB  = 72;
    localparam int unsigned RWA = $clog2(NA);
    localparam int unsigned RWB = $clog2(NB);

    localparam logic [4:0] ST_IDLE = 5'b00001;
    localparam logic [4:0] ST_KG   = 5'b00010;
    localparam logic [4:0] ST_ENC  = 5'b00100;
    localparam logic [4:0] ST_DEC  = 5'b01000;
    localparam logic [4:0] ST_DONE = 5'b10000;

    typedef struct packed {
        logic [4:0] st;
        logic [7:0] idx;
        logic       kge;
        logic       re;
        logic       busy;
        logic       done;
        logic       kv;
    } obs_t;

    typedef struct {
        logic [4:0] st;
        int         idx;
        bit         care;
        bit         kv;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rn_a, start_a, ctrl_a, key_new_a, abort_a;
    logic rn_b, start_b, ctrl_b, key_new_b, abort_b;
    logic [4:0]     state_a, state_b;
    logic [RWA-1:0] idx_a;
    logic [RWB-1:0] idx_b;
    logic kge_a, re_a, busy_a, done_a, kv_a;
    logic kge_b, re_b, busy_b, done_b, kv_b;

    int   n_vec = 0;
    int   n_err = 0;
    bit   kv_m [2];
    exp_t exp_a [$];
    exp_t exp_b [$];

    simon_round_ctrl #(.N_ROUNDS(NA), .KEY_CACHE(1'b1)) u_a (
        .clk(clk), .res_n(rn_a), .start(start_a), .ctrl(ctrl_a),
        .key_new(key_new_a), .abort(abort_a), .state(state_a),
        .rnd_idx(idx_a), .key_gen_en(kge_a), .round_en(re_a),
        .busy(busy_a), .done(done_a), .key_valid(kv_a)
    );

    simon_round_ctrl #(.N_ROUNDS(NB), .KEY_CACHE(1'b0)) u_b (
        .clk(clk), .res_n(rn_b), .start(start_b), .ctrl(ctrl_b),
        .key_new(key_new_b), .abort(abort_b), .state(state_b),
        .rnd_idx(idx_b), .key_gen_en(kge_b), .round_en(re_b),
        .busy(busy_b), .done(done_b), .key_valid(kv_b)
    );

    function automatic exp_t mk(input logic [4:0] st, input int idx, input bit care, input bit kv);
        exp_t e;
        e.st   = st;
        e.idx  = idx;
        e.care = care;
        e.kv   = kv;
        return e;
    endfunction

    function automatic obs_t get_obs(input int id);
        obs_t o;
        if (id == 0) begin
            o.st = state_a; o.idx = 8'(idx_a); o.kge = kge_a; o.re = re_a;
            o.busy = busy_a; o.done = done_a; o.kv = kv_a;
        end else begin
            o.st = state_b; o.idx = 8'(idx_b); o.kge = kge_b; o.re = re_b;
            o.busy = busy_b; o.done = done_b; o.kv = kv_b;
        end
        return o;
    endfunction

    // Expected strobes follow from the state meaning: generating, running rounds, not idle, finished.
    task automatic chk(input string nm, input obs_t a, input exp_t e);
        obs_t x;
        x.st   = e.st;
        x.idx  = e.care ? 8'(e.idx) : a.idx;
        x.kge  = (e.st == ST_KG);
        x.re   = (e.st == ST_ENC) || (e.st == ST_DEC);
        x.busy = (e.st != ST_IDLE);
        x.done = (e.st == ST_DONE);
        x.kv   = e.kv;
        n_vec++;
        if (a !== x) begin
            n_err++;
            $display("FAIL %s @%0t: got st=%b idx=%0d kge=%b re=%b busy=%b done=%b kv=%b, expected st=%b idx=%0d kge=%b re=%b busy=%b done=%b kv=%b",
                     nm, $time, a.st, a.idx, a.kge, a.re, a.busy, a.done, a.kv,
                     x.st, x.idx, x.kge, x.re, x.busy, x.done, x.kv);
        end
    endtask

    task automatic push_exp(input int id, input exp_t e);
        if (id == 0) exp_a.push_back(e);
        else         exp_b.push_back(e);
    endtask

    task automatic set_in(input int id, input bit s, input bit c, input bit kn, input bit ab);
        if (id == 0) begin start_a = s; ctrl_a = c; key_new_a = kn; abort_a = ab; end
        else         begin start_b = s; ctrl_b = c; key_new_b = kn; abort_b = ab; end
    endtask

    task automatic set_rst(input int id, input bit v);
        if (id == 0) rn_a = v;
        else         rn_b = v;
    endtask

    function automatic int qsize(input int id);
        return (id == 0) ? exp_a.size() : exp_b.size();
    endfunction

    // Wait (bounded) until the monitor has consumed every expectation.
    task automatic drain(input int id);
        for (int t = 0; t < 50; t++) begin
            if (qsize(id) == 0) break;
            @(negedge clk); #1;
        end
        if (qsize(id) != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout inst=%0d: %0d expectations left, required 0", id, qsize(id));
            if (id == 0) exp_a.delete();
            else         exp_b.delete();
        end
    endtask

    // Monitor: every sample with a pending expectation is compared.
    always @(negedge clk) begin
        exp_t e;
        if (exp_a.size() > 0) begin
            e = exp_a.pop_front();
            chk("mon_a", get_obs(0), e);
        end
        if (exp_b.size() > 0) begin
            e = exp_b.pop_front();
            chk("mon_b", get_obs(1), e);
        end
    end

    // One operation: build the cycle-by-cycle expected trace from the
    // sequencing rules, queue it, then drive start, noise, abort or reset.
    task automatic run_op(input int id, input bit c, input bit kn, input int abort_k, input int rst_k);
        int   n;
        bit   cache;
        bit   gen;
        bit   kv;
        int   nbusy;
        int   npush;
        exp_t seq [$];
        n     = (id == 0) ? NA : NB;
        cache = (id == 0);
        gen   = kn || !kv_m[id] || !cache;
        kv    = kv_m[id];
        if (gen) begin
            for (int i = 0; i < n; i++) seq.push_back(mk(ST_KG, i, 1'b1, 1'b0));
            kv = 1'b1;
        end
        for (int i = 0; i < n; i++)
            seq.push_back(c ? mk(ST_DEC, n - 1 - i, 1'b1, kv) : mk(ST_ENC, i, 1'b1, kv));
        seq.push_back(mk(ST_DONE, 0, 1'b0, kv));
        nbusy = seq.size();
        if (abort_k >= 0 && abort_k < nbusy) begin
            nbusy = abort_k + 1;
            kv    = seq[abort_k].kv;
        end
        if (rst_k >= 0 && rst_k < nbusy) nbusy = rst_k + 1;
        npush = (rst_k >= 0 && rst_k < nbusy) ? rst_k : nbusy;

        @(posedge clk); #1;
        push_exp(id, mk(ST_IDLE, 0, 1'b1, kv_m[id]));
        for (int i = 0; i < npush; i++) push_exp(id, seq[i]);
        if (!(rst_k >= 0 && rst_k < nbusy)) push_exp(id, mk(ST_IDLE, 0, 1'b1, kv));
        set_in(id, 1'b1, c, kn, 1'b0);
        @(posedge clk); #1;
        for (int k = 0; k < nbusy; k++) begin
            if (k == rst_k) begin
                set_in(id, 1'b0, 1'b0, 1'b0, 1'b0);
                #1 set_rst(id, 1'b0);
                #1 chk("async_reset", get_obs(id), mk(ST_IDLE, 0, 1'b1, 1'b0));
                repeat (2) @(posedge clk);
                #1 set_rst(id, 1'b1);
                kv_m[id] = 1'b0;
                drain(id);
                return;
            end
            set_in(id, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                   bit'($urandom_range(0, 1)), (k == abort_k));
            @(posedge clk); #1;
        end
        set_in(id, 1'b0, 1'b0, 1'b0, 1'b0);
        kv_m[id] = kv;
        drain(id);
    endtask

    // start together with abort in IDLE must leave the block idle.
    task automatic idle_abort(input int id);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) push_exp(id, mk(ST_IDLE, 0, 1'b1, kv_m[id]));
        set_in(id, 1'b1, bit'($urandom_range(0, 1)), 1'b1, 1'b1);
        @(posedge clk); #1;
        set_in(id, 1'b1, bit'($urandom_range(0, 1)), 1'b0, 1'b1);
        @(posedge clk); #1;
        set_in(id, 1'b0, 1'b0, 1'b0, 1'b0);
        drain(id);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit c_r;
        bit kn_r;
        int ab_r;
        kv_m[0] = 1'b0;
        kv_m[1] = 1'b0;
        rn_a = 1'b1;
        rn_b = 1'b1;
        set_in(0, 1'b0, 1'b0, 1'b0, 1'b0);
        set_in(1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        rn_a = 1'b0;
        rn_b = 1'b0;
        #1;
        chk("reset_a", get_obs(0), mk(ST_IDLE, 0, 1'b1, 1'b0));
        chk("reset_b", get_obs(1), mk(ST_IDLE, 0, 1'b1, 1'b0));
        repeat (2) @(posedge clk);
        #1;
        rn_a = 1'b1;
        rn_b = 1'b1;

        run_op(0, 1'b0, 1'b1, -1, -1);   // key gen then encrypt
        run_op(0, 1'b1, 1'b0, -1, -1);   // cached key, decrypt
        run_op(0, 1'b0, 1'b1, 10, -1);   // abort in KEY_GEN at idx 10
        run_op(0, 1'b0, 1'b0, -1, -1);   // schedule invalid: regenerates
        run_op(0, 1'b0, 1'b0, 5, -1);    // abort in ENC at idx 5
        run_op(0, 1'b0, 1'b0, -1, -1);   // straight to ENC
        run_op(0, 1'b1, 1'b0, -1, 12);   // async reset mid-DEC
        run_op(0, 1'b1, 1'b0, -1, -1);   // must regenerate after reset
        idle_abort(0);
        for (int r = 0; r < 6; r++) begin
            c_r  = bit'($urandom_range(0, 1));
            kn_r = ($urandom_range(0, 3) == 0);
            ab_r = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NA - 1)) : -1;
            run_op(0, c_r, kn_r, ab_r, -1);
        end

        run_op(1, 1'b0, 1'b0, -1, -1);   // no caching: always KEY_GEN
        run_op(1, 1'b0, 1'b0, -1, -1);
        run_op(1, 1'b1, 1'b0, -1, -1);
        idle_abort(1);
        run_op(1, 1'b1, 1'b0, 80, -1);   // abort in DEC
        run_op(1, 1'b0, 1'b0, -1, 30);   // async reset in KEY_GEN

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/simon_round_ctrl.md
Name: simon_round_ctrl

Overview:
- Parametrised successor to the SIMON mode FSM.
- Sequences key-schedule generation, then encryption or decryption, over a configurable number of rounds.
- Adds a round index, a round-key cache, abort and a one-cycle done pulse.
- Drives the key-expansion unit and round datapath; sits between the host interface and the SIMON core.

Parameters:
- N_ROUNDS, 32, rounds per block operation and round keys generated (32 = Simon32/64, 72 = Simon128/256); legal range ≥2.
- KEY_CACHE, 1, 1 = reuse a valid key schedule when key_new=0; 0 = always regenerate.
- RW (localparam), $clog2(N_ROUNDS), width of rnd_idx.

Ports:
- clk  in  1  clock, all state changes on rising edge.
- res_n  in  1  reset, asynchronous, active-low.
- start  in  1  request an operation; sampled in IDLE only.
- ctrl  in  1  0 = encrypt, 1 = decrypt; sampled with start.
- key_new  in  1  1 = new key present, force schedule regeneration; sampled with start.
- abort  in  1  terminate the current operation.
- state  out  5  one-hot: IDLE=00001, KEY_GEN=00010, ENC=00100, DEC=01000, DONE=10000.
- rnd_idx  out  RW  round-key index (write address in KEY_GEN, read address in ENC/DEC).
- key_gen_en  out  1  high in KEY_GEN.
- round_en  out  1  high in ENC or DEC.
- busy  out  1  high in any state except IDLE.
- done  out  1  high in DONE (exactly one cycle).
- key_valid  out  1  the key schedule in memory is complete.

Behaviour:
- Reset (res_n low, asynchronous):
  - state=IDLE, rnd_idx=0, key_valid=0, mode reg=0.
  - Hence key_gen_en=0, round_en=0, busy=0, done=0.
  - Reset mid-operation abandons it immediately; no done pulse.
- Registered: state, rnd_idx, key_valid, mode reg.
- Moore-decoded from state only: key_gen_en, round_en, busy, done.
- IDLE, on start=1 and abort=0:
  - Latch ctrl into the mode reg.
  - If key_new=1, or key_valid=0, or KEY_CACHE=0: go to KEY_GEN with rnd_idx=0 and key_valid cleared to 0.
  - Otherwise go to ENC (mode 0) with rnd_idx=0, or DEC (mode 1) with rnd_idx=N_ROUNDS-1.
- KEY_GEN:
  - rnd_idx increments each cycle.
  - When rnd_idx==N_ROUNDS-1: set key_valid=1, then go to ENC (rnd_idx=0) or DEC (rnd_idx=N_ROUNDS-1) per the mode reg.
  - Lasts exactly N_ROUNDS cycles.
- ENC: rnd_idx increments; when rnd_idx==N_ROUNDS-1, go to DONE. Lasts N_ROUNDS cycles.
- DEC: rnd_idx decrements; when rnd_idx==0, go to DONE. Lasts N_ROUNDS cycles.
- DONE: lasts one cycle, then goes to IDLE with rnd_idx=0.
- rnd_idx never wraps: the terminal compare always precedes any increment or decrement past the bounds.
- Latency (start sampled at edge E0):
  - Cached key: done high in the cycle after edge E(N_ROUNDS).
  - With key generation: done high in the cycle after edge E(2·N_ROUNDS).
- start, ctrl and key_new are ignored outside IDLE. A start held high through DONE begins a new operation only from IDLE, one cycle after DONE.
- abort:
  - Highest priority in every state.
  - From KEY_GEN/ENC/DEC/DONE: go to IDLE next edge with rnd_idx=0; done is not asserted.
  - Abort in KEY_GEN leaves key_valid=0.
  - Abort in ENC/DEC keeps key_valid.
  - abort and start together in IDLE: stay in IDLE.
- The state register is always one-hot. An illegal encoding recovers to IDLE on the next edge with rnd_idx=0.

Test Plan:
- N_ROUNDS=32: reset, then start=1, ctrl=0, key_new=1 → KEY_GEN 32 cycles (rnd_idx 0..31), ENC 32 cycles (rnd_idx 0..31), done pulse 1 cycle at cycle 65, key_valid=1 from cycle 33.
- Following start with ctrl=1, key_new=0 → KEY_GEN skipped; DEC 32 cycles with rnd_idx 31..0; done after 32 cycles; key_valid stays 1.
- abort at KEY_GEN with rnd_idx=10 → IDLE next cycle, key_valid=0, no done. The next start with key_new=0 still enters KEY_GEN.
- abort during ENC at rnd_idx=5 → IDLE, key_valid remains 1. The next start with ctrl=0, key_new=0 goes straight to ENC.
- Assert res_n=0 asynchronously mid-DEC → all outputs at reset values before the next clock edge; start pulses while busy=1 have no effect.
- KEY_CACHE=0, N_ROUNDS=72: start with key_new=0 twice → KEY_GEN each time (72 cycles), done at cycle 145 each; rnd_idx width 7.
